// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around an FFT core: loads N_POINTS samples, launches the core,
// waits for its result with a timeout, then drains the bins in natural or bit-reversed order.
module fft_frame_sequencer #(
    parameter int unsigned N_POINTS = 4,
    parameter int unsigned DW       = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         abort,
    input  logic                         bitrev_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    output logic                         core_start,
    output logic [N_POINTS*DW-1:0]       core_samples,
    input  logic                         core_done,
    input  logic [N_POINTS*DW-1:0]       core_freqs,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(N_POINTS)-1:0]  out_index,
    output logic                         out_last,
    output logic [3:0]                   status,
    output logic                         timeout_err,
    output logic [7:0]                   frame_cnt
);

    localparam int unsigned AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

    if (N_POINTS != 4 && N_POINTS != 8) begin : g_bad_n_points
        $error("fft_frame_sequencer: N_POINTS must be 4 or 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("fft_frame_sequencer: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        DRAIN
    } state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   ibuf [N_POINTS];
    logic [DW-1:0]   obuf [N_POINTS];
    logic [AW-1:0]   ld_cnt;
    logic [AW-1:0]   oc;
    logic [AW-1:0]   oc_rev;
    logic [AW-1:0]   oidx;
    logic [15:0]     timer;
    logic            frame_full;
    logic            br_mode;
    logic            in_fire;
    logic            ld_wrap;
    logic            out_fire;
    logic            last_fire;
    logic            time_up;
    logic            drain_act;

    for (genvar k = 0; k < N_POINTS; k++) begin : g_pack
        assign core_samples[k*DW +: DW] = ibuf[k];
    end

    always_comb begin
        oc_rev = '0;
        for (int unsigned b = 0; b < AW; b++) begin
            oc_rev[b] = oc[AW-1-b];
        end
    end

    assign oidx      = br_mode ? oc_rev : oc;
    assign drain_act = (state == DRAIN) && !rst;

    // Handshake and drain outputs are forced to their reset values during the reset cycle.
    assign in_ready   = !rst && ena && !frame_full && (state == LOAD || state == DRAIN);
    assign core_start = !rst && !abort && (state == START);
    assign out_valid  = drain_act && ena;
    assign out_data   = drain_act ? obuf[oidx] : '0;
    assign out_index  = drain_act ? oidx : '0;
    assign out_last   = drain_act && (oc == LAST_IDX);

    assign in_fire   = in_valid && in_ready;
    assign ld_wrap   = in_fire && (ld_cnt == LAST_IDX);
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && out_last;
    assign time_up   = (state == WAIT) && !core_done && (timer == TMO_LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:  if (frame_full) state_nx = START;
            START: state_nx = WAIT;
            WAIT: begin
                if (core_done)    state_nx = DRAIN;
                else if (time_up) state_nx = LOAD;
            end
            DRAIN: begin
                // A frame completed on this same edge still counts as ready to start.
                if (last_fire) state_nx = (frame_full || ld_wrap) ? START : LOAD;
            end
        endcase
        if (abort) state_nx = LOAD;
    end

    always_comb begin
        status = 4'hC;
        unique case (state)
            LOAD:  status = 4'(ld_cnt) + 4'd1;
            START,
            WAIT:  status = 4'hC;
            DRAIN: begin
                if (N_POINTS == 4) status = 4'h5 + 4'(oc);
                else               status = 4'h8 + 4'(oc);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            ld_cnt      <= '0;
            oc          <= '0;
            timer       <= '0;
            frame_full  <= 1'b0;
            br_mode     <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            for (int unsigned i = 0; i < N_POINTS; i++) begin
                ibuf[i] <= '0;
                obuf[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (abort) begin
                ld_cnt     <= '0;
                oc         <= '0;
                timer      <= '0;
                frame_full <= 1'b0;
            end else begin
                if (state == START) frame_full <= 1'b0;
                if (in_fire) begin
                    ibuf[ld_cnt] <= in_data;
                    if (ld_wrap) begin
                        ld_cnt     <= '0;
                        frame_full <= 1'b1;
                    end else begin
                        ld_cnt <= ld_cnt + 1'b1;
                    end
                end

                if (state == WAIT && !core_done && !time_up) timer <= timer + 16'd1;
                else                                        timer <= '0;

                if (state == WAIT && core_done) begin
                    br_mode <= bitrev_mode;
                    for (int unsigned i = 0; i < N_POINTS; i++) begin
                        obuf[i] <= core_freqs[i*DW +: DW];
                    end
                end

                if (time_up) timeout_err <= 1'b1;

                if (out_fire) begin
                    if (out_last) begin
                        oc        <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else begin
                        oc <= oc + 1'b1;
                    end
                end
            end
        end
    end

endmodule
